// File: rtl/fc_layer_sequencer_pkg.sv
// Shared types and defaults for the fully-connected layer sequencer.
package fc_seq_pkg;

  localparam int NUM_LAYERS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAC,
    S_FLUSH,
    S_WAIT,
    S_WR,
    S_NEXT,
    S_FIN
  } state_e;

  // Default network shape: input length and neuron count of each layer.
  localparam int DEF_L_IN  [NUM_LAYERS] = '{256, 100, 64};
  localparam int DEF_L_OUT [NUM_LAYERS] = '{100, 64, 10};

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Control/address bundle between the sequencer, the top-level control FSM,
// the shared datapath and the activation/weight/bias memories.
interface fc_seq_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              dp_ena;
  logic              dp_ena_add;
  logic              dp_acc_clr;
  logic [1:0]        dp_select;
  logic              act_rd_buf;
  logic [ADDR_W-1:0] act_rd_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              act_wr_buf;
  logic [ADDR_W-1:0] act_wr_addr;
  logic              act_we;

  modport master (
    input  start, stall,
    output busy, done, dp_ena, dp_ena_add, dp_acc_clr, dp_select,
           act_rd_buf, act_rd_addr, w_addr, b_addr,
           act_wr_buf, act_wr_addr, act_we
  );

  modport slave (
    output start, stall,
    input  busy, done, dp_ena, dp_ena_add, dp_acc_clr, dp_select,
           act_rd_buf, act_rd_addr, w_addr, b_addr,
           act_wr_buf, act_wr_addr, act_we
  );
endinterface

// File: rtl/fc_layer_sequencer_beat_counter.sv
// Loadable down-counter timing the MAC, FLUSH and WAIT phases.
// term_o is high while the count sits at zero, i.e. on the last beat of a phase.
module fc_beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  input  logic         stall_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a stall freezes the count, a load wins over a decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == '0);

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences the shared FC datapath through three layers, one neuron group
// at a time, and generates activation, weight and bias addresses.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int NUM_PARA = 1,
  parameter int L0_IN    = DEF_L_IN[0],
  parameter int L0_OUT   = DEF_L_OUT[0],
  parameter int L1_OUT   = DEF_L_OUT[1],
  parameter int L2_OUT   = DEF_L_OUT[2],
  parameter int MULT_LAT = 1,
  parameter int PIPE_LAT = 3,
  parameter int ADDR_W   = 16
) (
  input logic       clk,
  input logic       rst,
  fc_seq_if.master  bus
);

  localparam int MAX_LEN = maxOf(maxOf(maxOf(L0_IN, L0_OUT), maxOf(L1_OUT, L2_OUT)),
                                 maxOf(MULT_LAT, PIPE_LAT));
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  state_e            state_q, state_d;
  logic [1:0]        layer_q, layer_d;
  logic [CNT_W-1:0]  group_q, group_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] wAddr_q, wAddr_d;
  logic              rdBuf_q, rdBuf_d;

  logic [CNT_W-1:0]  lenIn;
  logic [CNT_W-1:0]  numGroups;
  logic [ADDR_W-1:0] biasBase;
  logic [ADDR_W-1:0] groupAddr;

  logic              cntLoad, cntDec, cntTerm;
  logic [CNT_W-1:0]  cntLoadVal;
  logic              holdStep;
  logic              dpEna, dpEnaAdd, accClr, wrStrobe, donePulse;

  fc_beat_counter #(.W(CNT_W)) u_beat (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cntLoad),
    .load_val_i (cntLoadVal),
    .dec_i      (cntDec),
    .stall_i    (holdStep),
    .term_o     (cntTerm)
  );

  // Per-layer geometry: input length, number of neuron groups, bias base.
  always_comb begin
    lenIn     = CNT_W'(L0_IN);
    numGroups = CNT_W'(L0_OUT / NUM_PARA);
    biasBase  = '0;
    case (layer_q)
      2'd1: begin
        lenIn     = CNT_W'(L0_OUT);
        numGroups = CNT_W'(L1_OUT / NUM_PARA);
        biasBase  = ADDR_W'(L0_OUT);
      end
      2'd2: begin
        lenIn     = CNT_W'(L1_OUT);
        numGroups = CNT_W'(L2_OUT / NUM_PARA);
        biasBase  = ADDR_W'(L0_OUT + L1_OUT);
      end
      default: ;
    endcase
  end

  // Next-state, counter updates and datapath strobes; a stall outside IDLE
  // reverts every update and suppresses every strobe so the step repeats.
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    group_d    = group_q;
    k_d        = k_q;
    wAddr_d    = wAddr_q;
    rdBuf_d    = rdBuf_q;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    cntDec     = 1'b0;
    dpEna      = 1'b0;
    dpEnaAdd   = 1'b0;
    accClr     = 1'b0;
    wrStrobe   = 1'b0;
    donePulse  = 1'b0;
    holdStep   = bus.stall && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLR;
          layer_d = 2'd0;
          group_d = '0;
          k_d     = '0;
          wAddr_d = '0;
          rdBuf_d = 1'b0;
        end
      end
      S_CLR: begin
        accClr     = 1'b1;
        k_d        = '0;
        cntLoad    = 1'b1;
        cntLoadVal = lenIn - CNT_W'(1);
        state_d    = S_MAC;
      end
      S_MAC: begin
        dpEna    = 1'b1;
        dpEnaAdd = 1'b1;
        k_d      = k_q + CNT_W'(1);
        wAddr_d  = wAddr_q + ADDR_W'(1);
        if (cntTerm) begin
          cntLoad    = 1'b1;
          cntLoadVal = CNT_W'(MULT_LAT - 1);
          state_d    = S_FLUSH;
        end else begin
          cntDec = 1'b1;
        end
      end
      S_FLUSH: begin
        dpEna    = 1'b1;
        dpEnaAdd = 1'b1;
        if (cntTerm) begin
          cntLoad    = 1'b1;
          cntLoadVal = CNT_W'(PIPE_LAT - 1);
          state_d    = S_WAIT;
        end else begin
          cntDec = 1'b1;
        end
      end
      S_WAIT: begin
        dpEna = 1'b1;
        if (cntTerm) state_d = S_WR;
        else         cntDec  = 1'b1;
      end
      S_WR: begin
        wrStrobe = 1'b1;
        group_d  = group_q + CNT_W'(1);
        if ((group_q + CNT_W'(1)) == numGroups) state_d = S_NEXT;
        else                                    state_d = S_CLR;
      end
      S_NEXT: begin
        rdBuf_d = ~rdBuf_q;
        group_d = '0;
        if (layer_q == 2'd2) begin
          layer_d = 2'd0;
          state_d = S_FIN;
        end else begin
          layer_d = layer_q + 2'd1;
          state_d = S_CLR;
        end
      end
      S_FIN: begin
        donePulse = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (holdStep) begin
      state_d   = state_q;
      layer_d   = layer_q;
      group_d   = group_q;
      k_d       = k_q;
      wAddr_d   = wAddr_q;
      rdBuf_d   = rdBuf_q;
      cntLoad   = 1'b0;
      cntDec    = 1'b0;
      dpEna     = 1'b0;
      dpEnaAdd  = 1'b0;
      accClr    = 1'b0;
      wrStrobe  = 1'b0;
      donePulse = 1'b0;
    end
  end

  // State and counter registers; reset aborts a run without any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= 2'd0;
      group_q <= '0;
      k_q     <= '0;
      wAddr_q <= '0;
      rdBuf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      group_q <= group_d;
      k_q     <= k_d;
      wAddr_q <= wAddr_d;
      rdBuf_q <= rdBuf_d;
    end
  end

  assign groupAddr       = ADDR_W'(group_q) * ADDR_W'(NUM_PARA);

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = donePulse;
  assign bus.dp_ena      = dpEna;
  assign bus.dp_ena_add  = dpEnaAdd;
  assign bus.dp_acc_clr  = accClr;
  assign bus.dp_select   = layer_q;
  assign bus.act_rd_buf  = rdBuf_q;
  assign bus.act_rd_addr = ADDR_W'(k_q);
  assign bus.w_addr      = wAddr_q;
  assign bus.b_addr      = biasBase + groupAddr;
  assign bus.act_wr_buf  = (state_q != S_IDLE) && !rdBuf_q;
  assign bus.act_wr_addr = groupAddr;
  assign bus.act_we      = wrStrobe;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: two instances, one with single-lane
// groups (A) and one with two-lane groups (B), sharing clock and reset.
module tb_fc_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic selB     = 1'b0;
  logic startDrv = 1'b0;
  logic stallDrv = 1'b0;

  fc_seq_if #(.ADDR_W(16)) busA ();
  fc_seq_if #(.ADDR_W(16)) busB ();

  assign busA.start = startDrv & ~selB;
  assign busA.stall = stallDrv & ~selB;
  assign busB.start = startDrv & selB;
  assign busB.stall = stallDrv & selB;

  fc_layer_sequencer #(
    .NUM_PARA(1), .L0_IN(4), .L0_OUT(3), .L1_OUT(2), .L2_OUT(2),
    .MULT_LAT(1), .PIPE_LAT(3), .ADDR_W(16)
  ) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  fc_layer_sequencer #(
    .NUM_PARA(2), .L0_IN(4), .L0_OUT(4), .L1_OUT(2), .L2_OUT(2),
    .MULT_LAT(1), .PIPE_LAT(3), .ADDR_W(16)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  logic        oBusy, oDone, oEna, oEnaAdd, oClr, oRdBuf, oWrBuf, oWe;
  logic [1:0]  oSel;
  logic [15:0] oRdAddr, oWAddr, oBAddr, oWrAddr;
  logic [73:0] allOut;

  // Observe whichever instance the current test is driving.
  always_comb begin
    if (selB) begin
      oBusy = busB.busy; oDone = busB.done; oEna = busB.dp_ena; oEnaAdd = busB.dp_ena_add;
      oClr = busB.dp_acc_clr; oSel = busB.dp_select; oRdBuf = busB.act_rd_buf;
      oRdAddr = busB.act_rd_addr; oWAddr = busB.w_addr; oBAddr = busB.b_addr;
      oWrBuf = busB.act_wr_buf; oWrAddr = busB.act_wr_addr; oWe = busB.act_we;
    end else begin
      oBusy = busA.busy; oDone = busA.done; oEna = busA.dp_ena; oEnaAdd = busA.dp_ena_add;
      oClr = busA.dp_acc_clr; oSel = busA.dp_select; oRdBuf = busA.act_rd_buf;
      oRdAddr = busA.act_rd_addr; oWAddr = busA.w_addr; oBAddr = busA.b_addr;
      oWrBuf = busA.act_wr_buf; oWrAddr = busA.act_wr_addr; oWe = busA.act_we;
    end
  end

  assign allOut = {oBusy, oDone, oEna, oEnaAdd, oClr, oSel, oRdBuf, oRdAddr,
                   oWAddr, oBAddr, oWrBuf, oWrAddr, oWe};

  int testsRun = 0;
  int testsFailed = 0;

  int lInA [3] = '{4, 3, 2};
  int lInB [3] = '{4, 4, 2};

  int doneCyc, doneCnt, busyCnt, clrCnt, clrMacCnt, rdErr, stallErr;
  int wCnt, weCnt;
  int wTrace   [64];
  int selTrace [64];
  int bTrace   [16];
  int wbTrace  [16];
  int waTrace  [16];
  int weSel    [16];

  // Runs one network on the selected instance, recording a trace.
  // Cycle c is the c-th cycle after the edge that accepted start.
  task automatic runDut(input bit useB, input int stallAt, input int stallLen,
                        input int repulseAt, input int maxCyc, input bit stallOnStart);
    int c, extra, macRem, lIn;
    bit prevClr;
    logic [15:0] heldW;
    selB = useB;
    doneCyc = 0; doneCnt = 0; busyCnt = 0; clrCnt = 0; clrMacCnt = 0;
    rdErr = 0; stallErr = 0; wCnt = 0; weCnt = 0;
    macRem = 0; lIn = 0; prevClr = 1'b0; heldW = '0; extra = -1;
    @(posedge clk); #1;
    startDrv = 1'b1; stallDrv = stallOnStart;
    @(posedge clk); #1;
    startDrv = 1'b0; stallDrv = 1'b0;
    c = 1;
    while (c <= maxCyc && extra != 0) begin
      stallDrv = (c >= stallAt) && (c < stallAt + stallLen);
      startDrv = (c == repulseAt);
      #1;
      if (oBusy) busyCnt++;
      if (oDone) begin
        doneCnt++;
        if (doneCyc == 0) begin doneCyc = c; extra = 4; end
      end
      if (oWe && weCnt < 16) begin
        bTrace[weCnt] = int'(oBAddr); wbTrace[weCnt] = int'(oWrBuf);
        waTrace[weCnt] = int'(oWrAddr); weSel[weCnt] = int'(oSel);
        weCnt++;
      end
      if (stallDrv) begin
        if (oEna || oEnaAdd || oClr || oWe || oDone) stallErr++;
        if (c == stallAt) heldW = oWAddr;
        else if (oWAddr !== heldW) stallErr++;
      end
      if (prevClr && !stallDrv) begin
        if (oEnaAdd) clrMacCnt++;
        prevClr = 1'b0;
      end
      if (oClr) begin
        clrCnt++;
        prevClr = 1'b1;
        if (oSel > 2'd2) lIn = 0;
        else if (useB) lIn = lInB[oSel];
        else lIn = lInA[oSel];
        macRem = lIn;
      end else if (oEnaAdd && macRem > 0) begin
        if (int'(oRdAddr) != lIn - macRem) rdErr++;
        if (wCnt < 64) begin
          wTrace[wCnt] = int'(oWAddr); selTrace[wCnt] = int'(oSel); wCnt++;
        end
        macRem--;
      end
      if (extra > 0) extra--;
      @(posedge clk); #1;
      c++;
    end
    startDrv = 1'b0; stallDrv = 1'b0;
  endtask

  // Reset leaves both instances idle with every output low; stall in IDLE is inert.
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    selB = 1'b0; #1;
    testsRun++;
    if (allOut !== '0) begin testsFailed++; $display("[TB] FAIL reset_outputs_A: got %h expected 0", allOut); end
    selB = 1'b1; #1;
    testsRun++;
    if (allOut !== '0) begin testsFailed++; $display("[TB] FAIL reset_outputs_B: got %h expected 0", allOut); end
    selB = 1'b0; stallDrv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if (allOut !== '0) begin testsFailed++; $display("[TB] FAIL idle_stall: got %h expected 0", allOut); end
    stallDrv = 1'b0;
  endtask

  // Full run: latency, busy window, write and done counts.
  task automatic test_basic_run();
    runDut(1'b0, 0, 0, 0, 200, 1'b0);
    testsRun++;
    if (doneCyc !== 68) begin testsFailed++; $display("[TB] FAIL basic_done_cycle: got %0d expected 68", doneCyc); end
    testsRun++;
    if (busyCnt !== 68) begin testsFailed++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 68", busyCnt); end
    testsRun++;
    if (weCnt !== 7) begin testsFailed++; $display("[TB] FAIL basic_we_count: got %0d expected 7", weCnt); end
    testsRun++;
    if (doneCnt !== 1) begin testsFailed++; $display("[TB] FAIL basic_done_count: got %0d expected 1", doneCnt); end
  endtask

  // Weight, bias, write-bank and write-address sequences plus activation read index.
  task automatic test_address_trace();
    int expB [7] = '{0, 1, 2, 3, 4, 5, 6};
    int expWb[7] = '{1, 1, 1, 0, 0, 1, 1};
    int expWa[7] = '{0, 1, 2, 0, 1, 0, 1};
    int expSel;
    runDut(1'b0, 0, 0, 0, 200, 1'b0);
    testsRun++;
    if (wCnt !== 22) begin testsFailed++; $display("[TB] FAIL w_addr_beats: got %0d expected 22", wCnt); end
    for (int i = 0; i < 22 && i < wCnt; i++) begin
      expSel = (i < 12) ? 0 : ((i < 18) ? 1 : 2);
      testsRun++;
      if (wTrace[i] !== i) begin testsFailed++; $display("[TB] FAIL w_addr[%0d]: got %0d expected %0d", i, wTrace[i], i); end
      testsRun++;
      if (selTrace[i] !== expSel) begin testsFailed++; $display("[TB] FAIL mac_select[%0d]: got %0d expected %0d", i, selTrace[i], expSel); end
    end
    testsRun++;
    if (rdErr !== 0) begin testsFailed++; $display("[TB] FAIL act_rd_addr_seq: got %0d bad beats expected 0", rdErr); end
    for (int i = 0; i < 7 && i < weCnt; i++) begin
      testsRun++;
      if (bTrace[i] !== expB[i]) begin testsFailed++; $display("[TB] FAIL b_addr[%0d]: got %0d expected %0d", i, bTrace[i], expB[i]); end
      testsRun++;
      if (wbTrace[i] !== expWb[i]) begin testsFailed++; $display("[TB] FAIL act_wr_buf[%0d]: got %0d expected %0d", i, wbTrace[i], expWb[i]); end
      testsRun++;
      if (waTrace[i] !== expWa[i]) begin testsFailed++; $display("[TB] FAIL act_wr_addr[%0d]: got %0d expected %0d", i, waTrace[i], expWa[i]); end
    end
  endtask

  // Layer select at each write and accumulator-clear placement.
  task automatic test_select_clr();
    int expSel[7] = '{0, 0, 0, 1, 1, 2, 2};
    runDut(1'b0, 0, 0, 0, 200, 1'b0);
    testsRun++;
    if (clrCnt !== 7) begin testsFailed++; $display("[TB] FAIL clr_count: got %0d expected 7", clrCnt); end
    testsRun++;
    if (clrMacCnt !== 7) begin testsFailed++; $display("[TB] FAIL clr_before_mac: got %0d expected 7", clrMacCnt); end
    for (int i = 0; i < 7 && i < weCnt; i++) begin
      testsRun++;
      if (weSel[i] !== expSel[i]) begin testsFailed++; $display("[TB] FAIL wr_select[%0d]: got %0d expected %0d", i, weSel[i], expSel[i]); end
    end
  endtask

  // Five-cycle stall in the MAC of layer 1 group 1 (cycles 43..47).
  task automatic test_stall();
    runDut(1'b0, 43, 5, 0, 200, 1'b0);
    testsRun++;
    if (doneCyc !== 73) begin testsFailed++; $display("[TB] FAIL stall_done_cycle: got %0d expected 73", doneCyc); end
    testsRun++;
    if (stallErr !== 0) begin testsFailed++; $display("[TB] FAIL stall_outputs: got %0d bad cycles expected 0", stallErr); end
    testsRun++;
    if (wCnt !== 22) begin testsFailed++; $display("[TB] FAIL stall_w_beats: got %0d expected 22", wCnt); end
    for (int i = 0; i < 22 && i < wCnt; i++) begin
      testsRun++;
      if (wTrace[i] !== i) begin testsFailed++; $display("[TB] FAIL stall_w_addr[%0d]: got %0d expected %0d", i, wTrace[i], i); end
    end
    testsRun++;
    if (weCnt !== 7) begin testsFailed++; $display("[TB] FAIL stall_we_count: got %0d expected 7", weCnt); end
  endtask

  // Start accepted even when stall is high in the same IDLE cycle.
  task automatic test_start_with_stall();
    runDut(1'b0, 0, 0, 0, 200, 1'b1);
    testsRun++;
    if (doneCyc !== 68) begin testsFailed++; $display("[TB] FAIL start_stall_done: got %0d expected 68", doneCyc); end
  endtask

  // Reset during WAIT of layer 0 group 2 (cycle 28) aborts; a fresh run then completes.
  task automatic test_reset_abort();
    runDut(1'b0, 0, 0, 0, 27, 1'b0);
    #1;
    testsRun++;
    if ({oEna, oEnaAdd, oBAddr} !== {1'b1, 1'b0, 16'd2}) begin
      testsFailed++; $display("[TB] FAIL abort_in_wait: got ena=%b add=%b b=%0d expected 1 0 2", oEna, oEnaAdd, oBAddr);
    end
    testsRun++;
    if (weCnt !== 2) begin testsFailed++; $display("[TB] FAIL abort_writes_before: got %0d expected 2", weCnt); end
    rst = 1'b1;
    @(posedge clk); #2;
    testsRun++;
    if (allOut !== '0) begin testsFailed++; $display("[TB] FAIL abort_outputs: got %h expected 0", allOut); end
    rst = 1'b0;
    @(posedge clk); #2;
    testsRun++;
    if ({oBusy, oWe} !== 2'b00) begin testsFailed++; $display("[TB] FAIL abort_idle: got busy=%b we=%b expected 0 0", oBusy, oWe); end
    runDut(1'b0, 0, 0, 0, 200, 1'b0);
    testsRun++;
    if (doneCyc !== 68) begin testsFailed++; $display("[TB] FAIL abort_rerun_done: got %0d expected 68", doneCyc); end
    testsRun++;
    if (weCnt !== 7) begin testsFailed++; $display("[TB] FAIL abort_rerun_we: got %0d expected 7", weCnt); end
  endtask

  // Two-lane instance with start re-pulsed mid-run.
  task automatic test_multi_lane_repulse();
    int expWa[4] = '{0, 2, 0, 0};
    int expB [4] = '{0, 2, 4, 6};
    runDut(1'b1, 0, 0, 10, 200, 1'b0);
    testsRun++;
    if (doneCyc !== 42) begin testsFailed++; $display("[TB] FAIL lane2_done_cycle: got %0d expected 42", doneCyc); end
    testsRun++;
    if (doneCnt !== 1) begin testsFailed++; $display("[TB] FAIL lane2_done_count: got %0d expected 1", doneCnt); end
    testsRun++;
    if (weCnt !== 4) begin testsFailed++; $display("[TB] FAIL lane2_we_count: got %0d expected 4", weCnt); end
    testsRun++;
    if (wCnt !== 14) begin testsFailed++; $display("[TB] FAIL lane2_w_beats: got %0d expected 14", wCnt); end
    for (int i = 0; i < 4 && i < weCnt; i++) begin
      testsRun++;
      if (waTrace[i] !== expWa[i]) begin testsFailed++; $display("[TB] FAIL lane2_wr_addr[%0d]: got %0d expected %0d", i, waTrace[i], expWa[i]); end
      testsRun++;
      if (bTrace[i] !== expB[i]) begin testsFailed++; $display("[TB] FAIL lane2_b_addr[%0d]: got %0d expected %0d", i, bTrace[i], expB[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_address_trace();
    test_select_clr();
    test_stall();
    test_start_with_stall();
    test_reset_abort();
    test_multi_lane_repulse();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
